// File: rtl/lsu.sv
// Load/store unit: turns one RISC-V load/store into one or two 64-bit memory
// accesses, splitting accesses that straddle an 8-byte word boundary.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d, data_q, data_d, asm_q, asm_d;
  logic [2:0]  f3_q, f3_d;
  logic        store_q, store_d, err_q, err_d;

  logic [2:0]  off;
  logic [3:0]  size, end_pos;
  logic [7:0]  mask, be1, be2;
  logic [5:0]  sh1, sh2;
  logic        split, accept, req_illegal;

  function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = f3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'b01:   extend = f3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10:   extend = f3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

  always_comb begin
    size = 4'd8;
    mask = 8'hFF;
    case (f3_q[1:0])
      2'b00:   begin size = 4'd1; mask = 8'h01; end
      2'b01:   begin size = 4'd2; mask = 8'h03; end
      2'b10:   begin size = 4'd4; mask = 8'h0F; end
      default: begin size = 4'd8; mask = 8'hFF; end
    endcase
  end

  // In ACC2 off is never 0, so (0 - off) mod 8 is the true 8 - off byte count.
  assign off     = addr_q[2:0];
  assign end_pos = {1'b0, off} + size;
  assign split   = end_pos > 4'd8;
  assign sh1     = {off, 3'b000};
  assign sh2     = {3'd0 - off, 3'b000};
  assign be1     = mask << off;
  assign be2     = (8'h01 << end_pos[2:0]) - 8'h01;

  assign req_illegal = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
  assign accept      = req_valid && (state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      asm_q   <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      asm_q   <= asm_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_illegal ? RESP : ACC1;
      ACC1:    state_d = split ? ACC2 : RESP;
      ACC2:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and load-data assembly; memory data is sampled at the edge ending each access.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    asm_d   = asm_q;
    f3_d    = f3_q;
    store_d = store_q;
    err_d   = err_q;
    if (accept) begin
      addr_d  = req_addr;
      data_d  = req_wdata;
      f3_d    = req_funct3;
      store_d = req_store;
      err_d   = req_illegal;
    end
    if (state_q == ACC1 && !store_q) asm_d = mem_rdata >> sh1;
    if (state_q == ACC2 && !store_q) asm_d = asm_q | (mem_rdata << sh2);
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ACC1: begin
        mem_addr  = {addr_q[63:3], 3'b000};
        mem_be    = be1;
        mem_wdata = data_q << sh1;
        mem_we    = store_q;
      end
      ACC2: begin
        mem_addr  = {addr_q[63:3], 3'b000} + 64'd8;
        mem_be    = be2;
        mem_wdata = data_q >> sh2;
        mem_we    = store_q;
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (store_q || err_q) ? 64'd0 : extend(asm_q, f3_q);
      end
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 4-word byte-enabled memory model plus hand-computed
// expectations for loads, stores, split accesses, illegal ops and reset.
module tb_lsu;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  logic        preload;
  logic [63:0] mem [0:3];
  int cyc_cnt = 0, acc_cnt = 0, acc_cyc = 0;
  int errors = 0, checks = 0;
  int acc_before;

  lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt++;
    if (req_valid && req_ready) acc_cnt++;
  end

  assign mem_rdata = mem[mem_addr[4:3]];

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 64'h8877665544332211;
      mem[1] <= 64'hFFEEDDCCBBAA9988;
      mem[2] <= 64'd0;
      mem[3] <= 64'd0;
    end else if (mem_we) begin
      for (int b = 0; b < 8; b++)
        if (mem_be[b]) mem[mem_addr[4:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] d, input bit hold);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 8) begin
      @(negedge clk);
      g++;
    end
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc_cnt;
    if (!hold) req_valid = 1'b0;
  endtask

  // Latency is the index of the response cycle, each cycle numbered by the edge that ends it.
  task automatic wait_resp(input string tag, input int exp_lat);
    while (!resp_valid && (cyc_cnt - acc_cyc) < 6) begin
      @(posedge clk);
      #1;
    end
    chk(tag, 64'(cyc_cnt - acc_cyc + 1), 64'(exp_lat));
  endtask

  initial begin
    reset = 1'b0; preload = 1'b1; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    #1 reset = 1'b1;
    #1;
    chk("rst_ready",  64'(req_ready),  64'd1);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_rerr",   64'(resp_err),   64'd0);
    chk("rst_rdata",  resp_rdata,      64'd0);
    chk("rst_we",     64'(mem_we),     64'd0);
    chk("rst_be",     64'(mem_be),     64'd0);
    chk("rst_addr",   mem_addr,        64'd0);
    chk("rst_wdata",  mem_wdata,       64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    preload = 1'b0;

    issue(1'b0, 3'b010, 64'h4, 64'd0, 1'b0);
    chk("lw_addr", mem_addr, 64'h0);
    chk("lw_be",   64'(mem_be), 64'hF0);
    chk("lw_we",   64'(mem_we), 64'd0);
    chk("lw_ready_busy", 64'(req_ready), 64'd0);
    wait_resp("lw_lat", 2);
    chk("lw_data", resp_rdata, 64'hFFFFFFFF88776655);
    chk("lw_err",  64'(resp_err), 64'd0);

    issue(1'b0, 3'b110, 64'h4, 64'd0, 1'b0);
    wait_resp("lwu_lat", 2);
    chk("lwu_data", resp_rdata, 64'h0000000088776655);

    issue(1'b0, 3'b011, 64'h5, 64'd0, 1'b0);
    chk("ld_a1_addr", mem_addr, 64'h0);
    chk("ld_a1_be",   64'(mem_be), 64'hE0);
    @(posedge clk); #1;
    chk("ld_a2_addr", mem_addr, 64'h8);
    chk("ld_a2_be",   64'(mem_be), 64'h1F);
    wait_resp("ld_lat", 3);
    chk("ld_data", resp_rdata, 64'hCCBBAA9988887766);

    issue(1'b1, 3'b001, 64'h7, 64'hABCD, 1'b0);
    chk("sh_a1_addr", mem_addr, 64'h0);
    chk("sh_a1_be",   64'(mem_be), 64'h80);
    chk("sh_a1_we",   64'(mem_we), 64'd1);
    chk("sh_a1_b7",   64'(mem_wdata[63:56]), 64'hCD);
    @(posedge clk); #1;
    chk("sh_a2_addr", mem_addr, 64'h8);
    chk("sh_a2_be",   64'(mem_be), 64'h01);
    chk("sh_a2_b0",   64'(mem_wdata[7:0]), 64'hAB);
    wait_resp("sh_lat", 3);
    chk("sh_rdata", resp_rdata, 64'd0);
    chk("sh_word0", mem[0], 64'hCD77665544332211);
    chk("sh_word1", mem[1], 64'hFFEEDDCCBBAA99AB);

    issue(1'b0, 3'b101, 64'h7, 64'd0, 1'b0);
    wait_resp("lhu_lat", 3);
    chk("lhu_data", resp_rdata, 64'h000000000000ABCD);
    issue(1'b0, 3'b001, 64'h7, 64'd0, 1'b0);
    wait_resp("lh_lat", 3);
    chk("lh_data", resp_rdata, 64'hFFFFFFFFFFFFABCD);

    issue(1'b1, 3'b000, 64'h3, 64'h5A, 1'b0);
    chk("sb_be",    64'(mem_be), 64'h08);
    chk("sb_lane",  64'(mem_wdata[31:24]), 64'h5A);
    wait_resp("sb_lat", 2);
    chk("sb_word0", mem[0], 64'hCD7766555A332211);
    issue(1'b0, 3'b000, 64'h3, 64'd0, 1'b0);
    wait_resp("lb_lat", 2);
    chk("lb_data", resp_rdata, 64'h000000000000005A);

    issue(1'b0, 3'b111, 64'h0, 64'd0, 1'b0);
    wait_resp("ill_ld_lat", 1);
    chk("ill_ld_err",   64'(resp_err), 64'd1);
    chk("ill_ld_rdata", resp_rdata, 64'd0);
    chk("ill_ld_be",    64'(mem_be), 64'd0);
    issue(1'b1, 3'b100, 64'h0, 64'hFFFF, 1'b0);
    wait_resp("ill_st_lat", 1);
    chk("ill_st_err",   64'(resp_err), 64'd1);
    chk("ill_st_we",    64'(mem_we), 64'd0);
    chk("ill_st_word0", mem[0], 64'hCD7766555A332211);

    acc_before = acc_cnt;
    issue(1'b0, 3'b011, 64'h5, 64'd0, 1'b1);
    chk("busy_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_rvalid", 64'(resp_valid), 64'd1);
    chk("busy_data", resp_rdata, 64'hCCBBAA99ABCD7766);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_accepts", 64'(acc_cnt - acc_before), 64'd1);

    issue(1'b1, 3'b011, 64'h4, 64'h0102030405060708, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_we_pre", 64'(mem_we), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we", 64'(mem_we), 64'd0);
    chk("rst_mid_be", 64'(mem_be), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_word0", mem[0], 64'h050607085A332211);
    chk("rst_mid_word1", mem[1], 64'hFFEEDDCCBBAA99AB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
